fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the program counter, drives the word address into the combinational instruction memory, and captures the returned 32-bit instruction into the IF/ID pipeline register. It sits directly upstream of the instruction memory and feeds the decode stage. It also handles stall, flush and taken-branch redirect requests from later stages.

## Interface
- ADDR_W, 4, word-address width of the instruction memory (16 words)
- NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on flush/redirect
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  hold PC and IF/ID (hazard unit)
- flush_i  in  1  replace IF/ID contents with bubble
- branch_taken_i  in  1  redirect fetch to branch_target_i
- branch_target_i  in  ADDR_W  word address of branch target
- instr_i  in  32  instruction returned by instruction memory for imem_addr_o
- imem_addr_o  out  ADDR_W  word address to instruction memory (= PC register)
- if_id_instr_o  out  32  latched instruction
- if_id_pc_next_o  out  ADDR_W  PC+1 of latched instruction
- if_id_valid_o  out  1  IF/ID holds a real instruction
- fetch_count_o  out  16  instructions accepted into IF/ID, saturating
- halted_o  out  1  fetch halted (see Configuration)

## Operation
- PC register drives imem_addr_o directly; memory is combinational, so instr_i is valid in the same cycle.
- Per-edge priority, highest first:
  - branch_taken_i: PC ← branch_target_i; IF/ID ← NOP_WORD, valid 0; pc_next ← 0. Overrides stall_i and flush_i.
  - flush_i: PC ← PC+1; IF/ID ← NOP_WORD, valid 0, pc_next 0.
  - stall_i: PC, IF/ID, counter all hold.
  - normal: IF/ID ← instr_i, pc_next ← PC+1, valid 1; PC ← PC+1; fetch_count_o increments.
- PC arithmetic is modulo 2^ADDR_W: PC 15 + 1 = 0 for ADDR_W=4; pc_next wraps identically.
- fetch_count_o increments only on normal-capture edges; it saturates at 16'hFFFF.
- halted_o is 0 whenever FETCH_HALT_EN is undefined.

## Timing
- Reset (async assert, sampled release): PC = 0; if_id_instr_o = NOP_WORD; if_id_pc_next_o = 0; if_id_valid_o = 0; fetch_count_o = 0; halted_o = 0.
- First fetch: address 0 on imem_addr_o during the first cycle after reset deasserts; memory[0] appears on if_id_instr_o after the next rising edge.
- Latency: one cycle from PC==A to if_id_instr_o = memory[A].
- Redirect: branch target appears on imem_addr_o in the cycle after the branch_taken_i edge. The instruction at the target reaches IF/ID one cycle later. Exactly one bubble is inserted.
- Stall: outputs are stable for as long as stall_i is high; the first edge after release performs a normal capture of the instruction at the held PC.
- Reset mid-operation: all state clears immediately, regardless of stall, flush or branch.

## Configuration
- FETCH_HALT_EN defined:
  - A normal capture of instr_i == 32'hFFFF_FFFF sets halted_o = 1. That word is latched with valid 1.
  - From then on, PC freezes, IF/ID is loaded with NOP_WORD/valid 0, and the counter holds.
  - Only reset or branch_taken_i clears halted_o. A redirect resumes fetch.
- FETCH_HALT_EN undefined: 32'hFFFF_FFFF is fetched like any other word; halted_o is tied 0.

## Structure
- Shared pipeline package: ADDR_W default, NOP_WORD, HALT_WORD (32'hFFFF_FFFF), and the IF/ID record typedef (instr, pc_next, valid).
- One sub-module is natural: pc_reg (PC register with next-PC mux: target / +1 / hold, and wrap). IF/ID latch, counter and halt logic stay in fetch_stage.
- Instruction memory is external and connected at the top level.

## Test plan
- Reset then free-run 4 cycles with memory[0..2] = 32'h00411821, 32'h00A32021, 32'h00452823 -> imem_addr_o 0,1,2,3; if_id_instr_o shows those words in order; pc_next 1,2,3; fetch_count_o = 4.
- Free-run from PC 14 -> imem_addr_o 14,15,0; after address 15, if_id_pc_next_o = 0.
- stall_i high 3 cycles at PC 2 -> imem_addr_o stays 2, IF/ID and counter unchanged; after release, memory[2] is latched.
- branch_taken_i with target 9 while stall_i and flush_i are also high -> next cycle imem_addr_o = 9 and IF/ID = NOP with valid 0; following edge latches memory[9].
- flush_i alone at PC 5 -> IF/ID = NOP with valid 0, imem_addr_o = 6, counter unchanged.
- With FETCH_HALT_EN and memory[3] = 32'hFFFFFFFF -> halted_o rises after capturing address 3, PC freezes at 4, valid drops to 0; branch_taken_i to 0 clears halted_o. Without the macro, halted_o stays 0 throughout.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants and the IF/ID record
package fetch_stage_pkg;
  localparam int ADDR_W = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  typedef struct packed {
    logic [31:0] instr;
    logic [ADDR_W-1:0] pc_next;
    logic valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// fetch_stage_pc_reg: program counter with target / +1 / hold next-PC mux, wrapping modulo 2^ADDR_W
module fetch_stage_pc_reg #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              hold,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_inc
);
  assign pc_inc = pc + ADDR_W'(1);
  // redirect wins over hold; otherwise advance by one word
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else if (load) pc <= target;
    else if (!hold) pc <= pc_inc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID latch, fetch counter and optional halt-on-HALT_WORD (FETCH_HALT_EN)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W   = fetch_stage_pkg::ADDR_W,
  parameter logic [31:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [31:0]       instr_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc_next_o,
  output logic              if_id_valid_o,
  output logic [15:0]       fetch_count_o,
  output logic              halted_o
);
  localparam int PW = $bits(if_id_t) - 33;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic halted, bubble, capture, pc_hold;
  logic [15:0] cnt;
  if_id_t if_id;
  assign bubble = branch_taken_i | halted | flush_i;
  assign capture = !bubble && !stall_i;
  assign pc_hold = !branch_taken_i && (halted || (!flush_i && stall_i));
  fetch_stage_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .clk(clk),
    .reset(reset),
    .load(branch_taken_i),
    .hold(pc_hold),
    .target(branch_target_i),
    .pc(pc),
    .pc_inc(pc_inc)
  );
  // IF/ID: bubble on redirect/halt/flush, hold on stall, else capture the fetched word
  always_ff @(posedge clk or posedge reset)
    if (reset) if_id <= '{instr: NOP_WORD, pc_next: '0, valid: 1'b0};
    else if (bubble) if_id <= '{instr: NOP_WORD, pc_next: '0, valid: 1'b0};
    else if (capture) if_id <= '{instr: instr_i, pc_next: PW'(pc_inc), valid: 1'b1};
  // saturating count of real captures
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (capture && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
`ifdef FETCH_HALT_EN
  // latch halt once HALT_WORD is captured; only a redirect resumes fetch
  always_ff @(posedge clk or posedge reset)
    if (reset) halted <= 1'b0;
    else if (branch_taken_i) halted <= 1'b0;
    else if (capture && instr_i == HALT_WORD) halted <= 1'b1;
`else
  assign halted = 1'b0;
`endif
  assign imem_addr_o = pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_pc_next_o = ADDR_W'(if_id.pc_next);
  assign if_id_valid_o = if_id.valid;
  assign fetch_count_o = cnt;
  assign halted_o = halted;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps with a reference model feeding an expected-state scoreboard
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset, stall_i, flush_i, branch_taken_i;
  logic [3:0] branch_target_i, imem_addr_o, if_id_pc_next_o;
  logic [31:0] instr_i, if_id_instr_o;
  logic if_id_valid_o, halted_o;
  logic [15:0] fetch_count_o;
  logic [31:0] mem [16];
  int passed = 0, total = 0;
  typedef struct {
    logic [3:0] addr;
    logic [31:0] instr;
    logic [3:0] pcn;
    logic valid;
    logic [15:0] cnt;
    logic halt;
  } exp_t;
  exp_t q[$];
  logic [3:0] m_pc, m_pcn;
  logic [31:0] m_instr;
  logic m_valid, m_halt;
  logic [15:0] m_cnt;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .instr_i(instr_i),
    .imem_addr_o(imem_addr_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_pc_next_o(if_id_pc_next_o),
    .if_id_valid_o(if_id_valid_o),
    .fetch_count_o(fetch_count_o),
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;
  assign instr_i = mem[imem_addr_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pcn = 0; m_valid = 0; m_cnt = 0; m_halt = 0;
  endtask

  task automatic step(input logic st, input logic fl, input logic br, input logic [3:0] tgt);
    exp_t e;
    logic [31:0] cur;
    cur = mem[m_pc];
    if (br) begin
      m_pc = tgt; m_instr = 0; m_pcn = 0; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      m_instr = 0; m_pcn = 0; m_valid = 0;
    end else if (fl) begin
      m_pc = m_pc + 4'd1; m_instr = 0; m_pcn = 0; m_valid = 0;
    end else if (!st) begin
      m_instr = cur; m_pcn = m_pc + 4'd1; m_valid = 1; m_pc = m_pc + 4'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifdef FETCH_HALT_EN
      m_halt = (cur == 32'hFFFF_FFFF);
`endif
    end
    e = '{m_pc, m_instr, m_pcn, m_valid, m_cnt, m_halt};
    q.push_back(e);
    stall_i = st; flush_i = fl; branch_taken_i = br; branch_target_i = tgt;
    @(posedge clk);
    #1;
    stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = 0;
    e = q.pop_front();
    chk("addr", imem_addr_o, e.addr);
    chk("instr", if_id_instr_o, e.instr);
    chk("pc_next", if_id_pc_next_o, e.pcn);
    chk("valid", if_id_valid_o, e.valid);
    chk("count", fetch_count_o, e.cnt);
    chk("halted", halted_o, e.halt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h2000_0000 | i;
    mem[0] = 32'h00411821; mem[1] = 32'h00A32021; mem[2] = 32'h00452823; mem[3] = 32'hFFFF_FFFF;
    reset = 1; stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_instr", if_id_instr_o, 0);
    chk("rst_pcn", if_id_pc_next_o, 0);
    chk("rst_valid", if_id_valid_o, 0);
    chk("rst_cnt", fetch_count_o, 0);
    chk("rst_halt", halted_o, 0);
    reset = 0;
    model_reset();
    chk("first_addr", imem_addr_o, 0);
    step(0, 0, 0, 0);
    chk("run_i0", if_id_instr_o, 32'h00411821);
    step(0, 0, 0, 0);
    chk("run_i1", if_id_instr_o, 32'h00A32021);
    step(0, 0, 0, 0);
    chk("run_i2", if_id_instr_o, 32'h00452823);
    chk("run_pcn2", if_id_pc_next_o, 3);
    step(0, 0, 0, 0);
    chk("run_cnt4", fetch_count_o, 4);
    chk("run_addr4", imem_addr_o, 4);
`ifdef FETCH_HALT_EN
    chk("halt_set", halted_o, 1);
    chk("halt_word_valid", if_id_valid_o, 1);
    step(0, 0, 0, 0);
    chk("halt_pc", imem_addr_o, 4);
    chk("halt_valid", if_id_valid_o, 0);
    chk("halt_cnt", fetch_count_o, 4);
`else
    chk("no_halt", halted_o, 0);
    chk("ffff_fetched", if_id_instr_o, 32'hFFFF_FFFF);
`endif
    step(0, 0, 1, 14);
    chk("halt_clr", halted_o, 0);
    step(0, 0, 0, 0);
    chk("wrap_a15", imem_addr_o, 15);
    step(0, 0, 0, 0);
    chk("wrap_addr", imem_addr_o, 0);
    chk("wrap_pcn", if_id_pc_next_o, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("stall_addr", imem_addr_o, 2);
    chk("stall_instr", if_id_instr_o, 32'h00A32021);
    step(0, 0, 0, 0);
    chk("stall_rel", if_id_instr_o, 32'h00452823);
    step(1, 1, 1, 9);
    chk("br_addr", imem_addr_o, 9);
    chk("br_valid", if_id_valid_o, 0);
    step(0, 0, 0, 0);
    chk("br_instr", if_id_instr_o, 32'h2000_0009);
    step(0, 0, 1, 4);
    step(0, 0, 0, 0);
    chk("pre_flush", imem_addr_o, 5);
    step(0, 1, 0, 0);
    chk("flush_addr", imem_addr_o, 6);
    chk("flush_instr", if_id_instr_o, 0);
    stall_i = 1; flush_i = 1; branch_taken_i = 1; branch_target_i = 7;
    #1 reset = 1;
    #1;
    chk("mid_rst_addr", imem_addr_o, 0);
    chk("mid_rst_valid", if_id_valid_o, 0);
    chk("mid_rst_cnt", fetch_count_o, 0);
    @(posedge clk);
    #1;
    reset = 0; stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = 0;
    mem[3] = 32'h0000_0003;
    repeat (65540) @(posedge clk);
    #1;
    m_pc = 4; m_instr = mem[3]; m_pcn = 4; m_valid = 1; m_cnt = 16'hFFFF; m_halt = 0;
    chk("sat_cnt", fetch_count_o, 16'hFFFF);
    chk("sat_addr", imem_addr_o, 4);
    step(0, 0, 0, 0);
    chk("sat_hold", fetch_count_o, 16'hFFFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
